// File: rtl/irq_pending_latch.sv
// Request-capture stage feeding an 8-input lowest-index-wins priority encoder.
// Define IRQ_SYNC_EN to pass req_in through a two-flop synchronizer per line.
module irq_pending_latch #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_in,
    input  logic [N-1:0]  mask,
    input  logic          edge_mode,
    input  logic          ack,
    input  logic [CW-1:0] ack_code,
    input  logic          ovf_clr,
    output logic [N-1:0]  sel,
    output logic          any_pend,
    output logic [N-1:0]  overflow
);

    logic [N-1:0] req_s;
    logic [N-1:0] req_prev_q;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] ovf_q, ovf_d;
    logic         mode_q;
    logic [N-1:0] rise;
    logic [N-1:0] ack_hit;
    logic [N-1:0] ovf_set;
    logic         mode_chg;

`ifdef IRQ_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req_in;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_in;
`endif

    assign rise     = req_s & ~req_prev_q;
    assign mode_chg = (edge_mode != mode_q);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            // Codes at or above N name no line and are ignored.
            assign ack_hit[gi] = ack && (int'(ack_code) == gi) && (int'(ack_code) < N);

            assign ovf_set[gi] = mode_q && !mode_chg && rise[gi] && pend_q[gi] && !ack_hit[gi];

            always_comb begin
                pend_d[gi] = pend_q[gi];
                if (mode_chg) begin
                    pend_d[gi] = 1'b0;
                end else if (!mode_q) begin
                    pend_d[gi] = req_s[gi];
                end else if (rise[gi]) begin
                    pend_d[gi] = 1'b1;
                end else if (ack_hit[gi]) begin
                    pend_d[gi] = 1'b0;
                end
            end

            // A new overflow on the same cycle as ovf_clr is kept.
            assign ovf_d[gi] = (ovf_q[gi] && !ovf_clr) || ovf_set[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            req_prev_q <= '0;
            mode_q     <= 1'b0;
            ovf_q      <= '0;
        end else begin
            pend_q     <= pend_d;
            req_prev_q <= req_s;
            mode_q     <= edge_mode;
            ovf_q      <= ovf_d;
        end
    end

    assign sel      = pend_q & mask;
    assign any_pend = |sel;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed self-checking bench for irq_pending_latch (default build, no synchronizer).
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       edge_mode;
    logic       ack;
    logic [2:0] ack_code;
    logic       ovf_clr;
    logic [7:0] sel;
    logic       any_pend;
    logic [7:0] overflow;

    int checks   = 0;
    int failures = 0;

    irq_pending_latch #(.N(8), .CW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .edge_mode (edge_mode),
        .ack       (ack),
        .ack_code  (ack_code),
        .ovf_clr   (ovf_clr),
        .sel       (sel),
        .any_pend  (any_pend),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_in = '0; mask = 8'hFF; edge_mode = 1'b0;
        ack = 1'b0; ack_code = '0; ovf_clr = 1'b0;
        step(); step();
        check("rst_sel", sel, 8'h00);
        check("rst_any", any_pend, 1'b0);
        check("rst_ovf", overflow, 8'h00);
        rst_n = 1'b1;
        step();
        check("rel_sel", sel, 8'h00);
        check("rel_ovf", overflow, 8'h00);

        // Enter edge mode and let mode_q settle.
        edge_mode = 1'b1;
        step(); step();

        // Single pulse on line 5 is captured and held, then acked.
        req_in = 8'h20; step();
        check("p5_sel", sel, 8'h20);
        check("p5_any", any_pend, 1'b1);
        req_in = 8'h00; step();
        check("p5_hold", sel, 8'h20);
        ack = 1'b1; ack_code = 3'd5; step();
        ack = 1'b0;
        check("p5_ack", sel, 8'h00);
        ack = 1'b1; ack_code = 3'd6; step();
        ack = 1'b0;
        check("ack_idle", sel, 8'h00);

        // Masked capture, then unmask is visible combinationally.
        mask = 8'hF0; req_in = 8'h04; step();
        req_in = 8'h00;
        check("m2_sel", sel, 8'h00);
        check("m2_any", any_pend, 1'b0);
        mask = 8'hFF; #1;
        check("m2_unmask", sel, 8'h04);
        check("m2_unmask_any", any_pend, 1'b1);
        ack = 1'b1; ack_code = 3'd2; step();
        ack = 1'b0;
        check("m2_ack", sel, 8'h00);

        // Overflow on a second rise of a pending line, then ovf_clr.
        req_in = 8'h08; step();
        req_in = 8'h00; step();
        check("o3_pre", overflow, 8'h00);
        req_in = 8'h08; step();
        check("o3_ovf", overflow, 8'h08);
        check("o3_sel", sel, 8'h08);
        req_in = 8'h00; ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        check("o3_clr", overflow, 8'h00);
        ack = 1'b1; ack_code = 3'd3; step();
        ack = 1'b0;
        check("o3_ack", sel, 8'h00);

        // Same-cycle rise and ack on a pending line: set wins, no overflow.
        req_in = 8'h02; step();
        req_in = 8'h00; step();
        req_in = 8'h02; ack = 1'b1; ack_code = 3'd1; step();
        req_in = 8'h00; ack = 1'b0;
        check("r1_sel", sel, 8'h02);
        check("r1_ovf", overflow, 8'h00);
        // Ack of a masked-but-pending line still clears it.
        mask = 8'hFD; ack = 1'b1; ack_code = 3'd1; step();
        ack = 1'b0; mask = 8'hFF; #1;
        check("r1_masked_ack", sel, 8'h00);

        // Overflow set on the same cycle as ovf_clr is kept.
        req_in = 8'h01; step();
        req_in = 8'h00; step();
        req_in = 8'h01; ovf_clr = 1'b1; step();
        req_in = 8'h00; ovf_clr = 1'b0;
        check("o0_setwins", overflow, 8'h01);
        ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        check("o0_clr", overflow, 8'h00);
        ack = 1'b1; ack_code = 3'd0; step();
        ack = 1'b0;
        check("o0_ack", sel, 8'h00);

        // Level mode: follows req, ignores ack; mode toggle clears pend.
        edge_mode = 1'b0; req_in = 8'h81; step();
        check("lv_chg", sel, 8'h00);
        step();
        check("lv_sel", sel, 8'h81);
        check("lv_any", any_pend, 1'b1);
        ack = 1'b1; ack_code = 3'd0; step();
        ack = 1'b0;
        check("lv_ack_ign", sel, 8'h81);
        req_in = 8'h00; step();
        check("lv_low", sel, 8'h00);
        req_in = 8'h81; step();
        check("lv_high", sel, 8'h81);
        edge_mode = 1'b1; step();
        check("tog_clear", sel, 8'h00);
        step();
        check("cont_high", sel, 8'h00);
        check("cont_ovf", overflow, 8'h00);

        // Asynchronous reset mid-operation.
        edge_mode = 1'b0; req_in = 8'h10; step(); step();
        check("pre_rst", sel, 8'h10);
        #2 rst_n = 1'b0; #1;
        check("async_rst", sel, 8'h00);
        check("async_rst_any", any_pend, 1'b0);
        step();
        rst_n = 1'b1; step();
        check("post_rst", sel, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
